// File: rtl/recurrence_unwind_if.sv
// Start/ready/done handshake and data bus between a recurrence_unwind
// requester (master) and the unwinder itself (slave).
interface recurrence_unwind_if #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 4
);
    logic              start;
    logic [ITER_W-1:0] iters;
    logic [WIDTH-1:0]  b_in;
    logic [WIDTH-1:0]  c_in;
    logic              ready;
    logic              done;
    logic [WIDTH-1:0]  b_out;
    logic [WIDTH-1:0]  c_out;

    modport master (
        output start, iters, b_in, c_in,
        input  ready, done, b_out, c_out
    );

    modport slave (
        input  start, iters, b_in, c_in,
        output ready, done, b_out, c_out
    );
endinterface

// File: rtl/recurrence_unwind.sv
// Recovers the initial (b, c) of the forward recurrence from its final values,
// undoing one iteration every two cycles: first c -= 1, then b -= c + 7.
module recurrence_unwind #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    recurrence_unwind_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, UNDO_C, UNDO_B, DONE} state_t;

    localparam logic [WIDTH-1:0] SEVEN = WIDTH'(7);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic [ITER_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    b_d     = bus.b_in;
                    c_d     = bus.c_in;
                    cnt_d   = bus.iters;
                    state_d = (bus.iters == '0) ? DONE : UNDO_C;
                end
            end
            UNDO_C: begin
                c_d     = c_q - 1'b1;
                state_d = UNDO_B;
            end
            UNDO_B: begin
                // c_q already holds the decremented c, matching the forward order.
                b_d     = b_q - c_q - SEVEN;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == ITER_W'(1)) ? DONE : UNDO_C;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.b_out = b_q;
    assign bus.c_out = c_q;
endmodule

// File: tb/tb_recurrence_unwind.sv
// Directed and randomized bench for recurrence_unwind; expected values come
// from running the forward recurrence on a chosen initial (b, c).
module tb_recurrence_unwind;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    recurrence_unwind_if #(.WIDTH(32), .ITER_W(4)) bus ();

    recurrence_unwind #(.WIDTH(32), .ITER_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fwd_step(input logic [31:0] b, input logic [31:0] c);
        logic [31:0] a, d;
        a = b + c;
        d = a - 32'd3;
        return {d + 32'd10, c + 32'd1};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Runs one job whose initial values are (b0, c0); starts and ends at a negedge in IDLE.
    // With hold set, start stays high with the next job's operands throughout.
    task automatic run_job(input string tag, input int n, input logic [31:0] b0,
                           input logic [31:0] c0, input bit hold, input int nn,
                           input logic [31:0] nb, input logic [31:0] nc);
        logic [31:0] tb_b [0:15];
        logic [31:0] tb_c [0:15];
        logic [31:0] obs_b [0:63];
        logic [31:0] obs_c [0:63];
        int cycles;
        int busy_bad;
        tb_b[0] = b0;
        tb_c[0] = c0;
        for (int i = 0; i < n; i++) {tb_b[i+1], tb_c[i+1]} = fwd_step(tb_b[i], tb_c[i]);
        check({tag, "_ready_idle"}, 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.iters = 4'(n);
        bus.b_in  = tb_b[n];
        bus.c_in  = tb_c[n];
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            bus.iters = 4'(nn);
            bus.b_in  = nb;
            bus.c_in  = nc;
        end else begin
            bus.start = 1'b0;
        end
        cycles   = 0;
        busy_bad = 0;
        while (!bus.done && cycles < 40) begin
            obs_b[cycles] = bus.b_out;
            obs_c[cycles] = bus.c_out;
            if (bus.ready !== 1'b0) busy_bad++;
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_latency"}, 32'(cycles), 32'(2 * n));
        check({tag, "_ready_busy"}, 32'(busy_bad), 32'd0);
        check({tag, "_ready_in_done"}, 32'(bus.ready), 32'd0);
        check({tag, "_b_out"}, bus.b_out, b0);
        check({tag, "_c_out"}, bus.c_out, c0);
        if (cycles == 2 * n) begin
            for (int j = 1; j <= n; j++) begin
                check($sformatf("%s_mid_c%0d", tag, j), obs_c[2*j-1], tb_c[n-j]);
                if (j < n) check($sformatf("%s_mid_b%0d", tag, j), obs_b[2*j], tb_b[n-j]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_single_done"}, 32'(bus.done), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
        check({tag, "_b_hold"}, bus.b_out, b0);
        check({tag, "_c_hold"}, bus.c_out, c0);
    endtask

    initial begin
        logic [31:0] rb, rc, fb, fc;
        int dones;
        bus.start = 1'b0;
        bus.iters = '0;
        bus.b_in  = '0;
        bus.c_in  = '0;
        @(negedge clk);
        check("reset_ready", 32'(bus.ready), 32'd1);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_b", bus.b_out, 32'd0);
        check("reset_c", bus.c_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_job("nominal", 4, 32'd20, 32'd15, 1'b0, 0, '0, '0);
        run_job("zero_iters", 0, 32'd5, 32'd6, 1'b0, 0, '0, '0);
        run_job("wrap", 1, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 0, '0, '0);
        run_job("max_count", 15, -32'sd100, 32'd7, 1'b0, 0, '0, '0);

        // Second job's operands are driven through the first job's busy and DONE cycles.
        rb = $urandom;
        rc = $urandom;
        {fb, fc} = fwd_step(rb, rc);
        run_job("busy_first", 2, 32'd1000, 32'd33, 1'b1, 1, fb, fc);
        run_job("busy_second", 1, rb, rc, 1'b0, 0, '0, '0);

        // Abort an iters=3 job while it sits in UNDO_B.
        rb = $urandom;
        rc = $urandom;
        {fb, fc} = fwd_step(rb, rc);
        {fb, fc} = fwd_step(fb, fc);
        {fb, fc} = fwd_step(fb, fc);
        bus.start = 1'b1;
        bus.iters = 4'd3;
        bus.b_in  = fb;
        bus.c_in  = fc;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_b", bus.b_out, 32'd0);
        check("abort_c", bus.c_out, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_idle", 32'(bus.ready), 32'd1);
        run_job("after_abort", 3, rb, rc, 1'b0, 0, '0, '0);

        for (int t = 0; t < 6; t++) begin
            run_job($sformatf("rand%0d", t), int'($urandom_range(0, 7)),
                    $urandom, $urandom, 1'b0, 0, '0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/recurrence_unwind.md
# recurrence_unwind

Sequential inverse of the team's four-step integer recurrence (a = b + c; d = a − 3; b = d + 10; c = c + 1, repeated N times). Given the final (b, c) and the iteration count N, it recovers the initial (b, c) by undoing one iteration per two clock cycles. Each cycle performs one ordered update, so the forward statement ordering is unwound in reverse. It sits beside the forward recurrence model as its checker and decoder, behind a start/ready/done handshake.

## Interface
- WIDTH, default 32: data width; all arithmetic is two's complement, modulo 2^WIDTH.
- ITER_W, default 4: width of the iteration count.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; sampled only while ready = 1.
- iters  input  ITER_W  N, the number of forward iterations to undo; sampled with start.
- b_in  input  WIDTH  final b of the forward run; sampled with start.
- c_in  input  WIDTH  final c of the forward run; sampled with start.
- ready  output  1  high in IDLE only.
- done  output  1  single-cycle pulse; b_out and c_out are valid in that cycle.
- b_out  output  WIDTH  working and recovered b.
- c_out  output  WIDTH  working and recovered c.

## Operation
- Registers:
  - b_r, c_r (WIDTH bits), driving b_out and c_out directly.
  - cnt (ITER_W bits).
  - state ∈ {IDLE, UNDO_C, UNDO_B, DONE}.
- Inverse derivation: the forward step gives c' = c + 1 and b' = b + c + 7. Therefore c = c' − 1 and b = b' − c − 7, where the b update uses the already-decremented c.
- IDLE:
  - ready = 1.
  - On start = 1: b_r ← b_in, c_r ← c_in, cnt ← iters.
  - Next state is DONE if iters = 0, otherwise UNDO_C.
  - With start = 0, hold all registers.
- UNDO_C: c_r ← c_r − 1; next state UNDO_B.
- UNDO_B:
  - b_r ← b_r − c_r − 7, using the c_r value decremented in the previous cycle.
  - cnt ← cnt − 1.
  - Next state is DONE if cnt = 1, otherwise UNDO_C.
- DONE: done = 1; b_r and c_r hold; next state IDLE unconditionally.
- Start handling:
  - start outside IDLE, including in DONE, is ignored. It is neither queued nor able to corrupt the registers.
  - The earliest new accept is the first IDLE cycle after DONE.
- Arithmetic: results wrap modulo 2^WIDTH with no saturation and no overflow flag. 7 is a WIDTH-bit constant.
- Maximum N is 2^ITER_W − 1. The iters encoding 0 means no unwinding, not 2^ITER_W.

## Timing
- Reset state: state = IDLE, b_r = 0, c_r = 0, cnt = 0, ready = 1, done = 0.
- Reset mid-operation: an asynchronous abort to the reset state. No done pulse is produced for the aborted job.
- Latency: let edge k sample start. done is high in the cycle after edge k + 2N. For N = 0 that is the cycle immediately after edge k.
- ready falls in the cycle after edge k and returns in the cycle after the DONE cycle. Total occupancy is 2N + 2 cycles from the accept edge to the next possible accept edge.
- done lasts exactly one cycle per accepted start.
- b_out and c_out show intermediate values while busy. They are meaningful only when done = 1 and hold until the next accept or reset.
- ready and done are registered-state decodes, with no combinational path from start.

## Test plan
- **Nominal:** iters = 4, b_in = 114, c_in = 19.
  - Required: b_out = 20 and c_out = 15 with done in the cycle after edge k + 8.
  - Intermediate c_out sequence: 18, 17, 16, 15. Intermediate b_out sequence: 89, 65, 42, 20.
- **Zero iterations:** iters = 0, b_in = 5, c_in = 6.
  - Required: done in the cycle after the accept edge, b_out = 5, c_out = 6, ready high one cycle later.
- **Wrap-around:** WIDTH = 32, iters = 1, b_in = 0, c_in = 0.
  - Required: c_out = 32'hFFFFFFFF, b_out = 32'hFFFFFFFA.
  - Feeding these back through the forward model must reproduce 0, 0.
- **Busy and DONE protection:** after accepting iters = 2, hold start = 1 with different b_in/c_in through every busy cycle and the DONE cycle.
  - Required: the result matches the first job.
  - Exactly one done for the first job, then a second done for a new job accepted in the following IDLE cycle.
- **Reset mid-operation:** assert rst during UNDO_B of an iters = 3 job.
  - Required: immediately state = IDLE, b_out = c_out = 0, ready = 1, and no done pulse.
  - A subsequent job completes correctly.
- **Maximum count:** iters = 15, with b_in and c_in computed by the forward model from b = −100, c = 7.
  - Required: b_out = −100, c_out = 7, done in the cycle after edge k + 30.
